// File: rtl/seq_num_alloc.sv
// -----------------------------------------------------------------------------
// seq_num_alloc
//
// Purpose:
//   Allocates in-order sequence numbers to instructions entering the
//   out-of-order window and retires them in order as commit notifications
//   arrive. It publishes the oldest in-flight number, which age comparators
//   use as their wrap-around reference. It also throttles dispatch when the
//   window is full.
//
// Parameters:
//   p_seq_num_bits  - width of a sequence number; numbers wrap modulo
//                     2**p_seq_num_bits.
//   p_max_in_flight - maximum outstanding numbers, 1..2**p_seq_num_bits.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   alloc_val      in   dispatch requests a sequence number
//   alloc_rdy      out  a number can be granted this cycle
//   alloc_seq_num  out  number granted when alloc_val && alloc_rdy
//   commit_val     in   commit notification valid
//   commit_seq_num in   number being committed (must be the oldest)
//   squash_val     in   (optional) squash request
//   squash_seq_num in   (optional) keep this number and older, free younger
//   oldest_seq_num out  oldest in-flight number (next-to-allocate when empty)
//   num_in_flight  out  outstanding count
//   empty          out  num_in_flight == 0
//   err            out  registered one-cycle pulse for an illegal
//                       commit or squash
//
// Configuration:
//   SEQ_NUM_ALLOC_SQUASH_EN - when defined, adds the squash_val and
//   squash_seq_num ports and the partial-flush behaviour. When it is
//   undefined, head moves only on an allocation or on reset.
// -----------------------------------------------------------------------------
module seq_num_alloc #(
    parameter int p_seq_num_bits  = 5,
    parameter int p_max_in_flight = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alloc_val,
    output logic                                   alloc_rdy,
    output logic [p_seq_num_bits-1:0]              alloc_seq_num,
    input  logic                                   commit_val,
    input  logic [p_seq_num_bits-1:0]              commit_seq_num,
`ifdef SEQ_NUM_ALLOC_SQUASH_EN
    input  logic                                   squash_val,
    input  logic [p_seq_num_bits-1:0]              squash_seq_num,
`endif
    output logic [p_seq_num_bits-1:0]              oldest_seq_num,
    output logic [$clog2(p_max_in_flight+1)-1:0]   num_in_flight,
    output logic                                   empty,
    output logic                                   err
);

    localparam int CNT_BITS = $clog2(p_max_in_flight + 1);
    localparam logic [CNT_BITS-1:0]       MAX_CNT  = CNT_BITS'(p_max_in_flight);
    localparam logic [CNT_BITS-1:0]       CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0]       CNT_ONE  = CNT_BITS'(1'b1);
    localparam logic [p_seq_num_bits-1:0] SEQ_ZERO = {p_seq_num_bits{1'b0}};
    localparam logic [p_seq_num_bits-1:0] SEQ_ONE  = p_seq_num_bits'(1'b1);

    // Architectural state: head is the next number to hand out. tail is
    // the oldest in-flight number. count tells full apart from empty,
    // because head == tail is ambiguous when the window spans every number.
    logic [p_seq_num_bits-1:0] head_q, head_d;
    logic [p_seq_num_bits-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0]       count_q, count_d;
    logic                      err_q, err_d;

    // Per-cycle event decode.
    logic                      alloc_rdy_s;
    logic                      alloc_fire_s;
    logic                      commit_legal_s;
    logic                      commit_illegal_s;
    logic                      squash_act_s;
    logic                      squash_legal_s;
    logic                      squash_illegal_s;

    // Next-state values for an ordinary cycle, before any squash override.
    logic [p_seq_num_bits-1:0] head_nrm_s;
    logic [CNT_BITS-1:0]       count_nrm_s;

`ifdef SEQ_NUM_ALLOC_SQUASH_EN
    // Distance of the squash point from the oldest entry. This is its age
    // within the window.
    logic [p_seq_num_bits-1:0] squash_dist_s;
    logic [31:0]               squash_cnt_s;
`endif

    // Commit legality: only the oldest in-flight number can retire.
    always_comb begin
        commit_legal_s   = commit_val && (count_q != CNT_ZERO) &&
                           (commit_seq_num == tail_q);
        commit_illegal_s = commit_val && !commit_legal_s;
    end

`ifdef SEQ_NUM_ALLOC_SQUASH_EN
    // Squash legality: the kept number must currently be in flight.
    always_comb begin
        squash_act_s     = squash_val;
        squash_dist_s    = squash_seq_num - tail_q;
        squash_legal_s   = squash_val &&
                           (32'(squash_dist_s) < 32'(count_q));
        squash_illegal_s = squash_val && !squash_legal_s;
        // Survivors are tail..squash point inclusive. A same-cycle legal
        // commit removes one more survivor from the front.
        if (commit_legal_s) begin
            squash_cnt_s = 32'(squash_dist_s) + 32'd1 - 32'd1;
        end else begin
            squash_cnt_s = 32'(squash_dist_s) + 32'd1;
        end
    end
`else
    // Squash support is not built. Hold the squash events inactive.
    always_comb begin
        squash_act_s     = 1'b0;
        squash_legal_s   = 1'b0;
        squash_illegal_s = 1'b0;
    end
`endif

    // Dispatch handshake. A same-cycle commit is deliberately not forwarded
    // into ready, so that ready stays a function of registered state (plus
    // squash).
    always_comb begin
        alloc_rdy_s  = (count_q < MAX_CNT) && !squash_act_s;
        alloc_fire_s = alloc_val && alloc_rdy_s;
    end

    // Ordinary next state: allocation advances head, and a legal commit
    // advances tail. The count moves only when exactly one of them happens.
    always_comb begin
        if (alloc_fire_s) begin
            head_nrm_s = head_q + SEQ_ONE;
        end else begin
            head_nrm_s = head_q;
        end

        if (commit_legal_s) begin
            tail_d = tail_q + SEQ_ONE;
        end else begin
            tail_d = tail_q;
        end

        case ({alloc_fire_s, commit_legal_s})
            2'b10:   count_nrm_s = count_q + CNT_ONE;
            2'b01:   count_nrm_s = count_q - CNT_ONE;
            default: count_nrm_s = count_q;
        endcase
    end

    // Final head/count selection. A legal squash rewinds head to just past
    // the kept number. It never coincides with an allocation, because
    // squash forces alloc_rdy low.
    always_comb begin
`ifdef SEQ_NUM_ALLOC_SQUASH_EN
        if (squash_legal_s) begin
            head_d  = squash_seq_num + SEQ_ONE;
            count_d = CNT_BITS'(squash_cnt_s);
        end else begin
            head_d  = head_nrm_s;
            count_d = count_nrm_s;
        end
`else
        head_d  = head_nrm_s;
        count_d = count_nrm_s;
`endif
        err_d = commit_illegal_s || squash_illegal_s;
    end

    // State registers. Reset discards everything in flight and ignores any
    // commit presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= SEQ_ZERO;
            tail_q  <= SEQ_ZERO;
            count_q <= CNT_ZERO;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Outputs are taken straight from the registers. Only alloc_rdy also
    // sees squash.
    always_comb begin
        alloc_rdy      = alloc_rdy_s;
        alloc_seq_num  = head_q;
        oldest_seq_num = tail_q;
        num_in_flight  = count_q;
        empty          = (count_q == CNT_ZERO);
        err            = err_q;
    end

endmodule
